regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result path (req 0) and load/store unit load-return path (req 1).
- Fixed priority to the LSU, with an anti-starvation counter for the ALU.
- Registered output stage drives the register file write port.
- Keeps a pending-load scoreboard so decode can stall on read-after-write hazards against outstanding loads.

Parameters:
- REG_COUNT, 32, number of architectural registers (x0 hardwired zero)
- ADDR_WIDTH, $clog2(REG_COUNT), register address width
- DATA_WIDTH, 32, register data width
- MAX_WAIT, 4, consecutive ALU-denied cycles before the ALU is granted priority for one cycle

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid_i  in  1  ALU writeback request
- alu_ready_o  out  1  ALU request accepted this cycle when valid&ready
- alu_waddr_i  in  ADDR_WIDTH  ALU destination register
- alu_wdata_i  in  DATA_WIDTH  ALU result
- lsu_valid_i  in  1  load-return writeback request
- lsu_ready_o  out  1  LSU request accepted when valid&ready
- lsu_waddr_i  in  ADDR_WIDTH  load destination register
- lsu_wdata_i  in  DATA_WIDTH  load data
- issue_load_i  in  1  a load is issued this cycle
- issue_rd_i  in  ADDR_WIDTH  destination of issued load
- query_a_i  in  ADDR_WIDTH  decode source register a
- query_b_i  in  ADDR_WIDTH  decode source register b
- hazard_o  out  1  a queried source has a pending load
- waddr_o  out  ADDR_WIDTH  to register file write address
- wdata_o  out  DATA_WIDTH  to register file write data
- we_o  out  1  to register file write enable

Behaviour:
- Reset (async, rst_n=0):
  - we_o=0, waddr_o=0, wdata_o=0.
  - Scoreboard cleared; starvation counter=0; output-stage source flag=ALU.
  - alu_ready_o/lsu_ready_o are combinational but forced 0 while rst_n=0.
  - Reset mid-operation discards any write held in the output stage; it is never committed.
- Handshake:
  - Valid/ready per requester.
  - A transfer occurs when valid&ready at a rising edge.
  - A requester holds waddr/wdata stable while valid and not ready.
  - ready is never a function of the same requester's valid.
- Arbitration (combinational, one grant per cycle):
  - Default: lsu_ready_o=1.
  - Default: alu_ready_o = !lsu_valid_i.
  - Starvation override: if wait_cnt==MAX_WAIT, then alu_ready_o=1 and lsu_ready_o=0 for that cycle.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) each cycle with alu_valid_i=1 and alu_ready_o=0.
  - Resets to 0 on any ALU transfer or on any cycle with alu_valid_i=0.
- Output stage (1-cycle latency):
  - A transfer in cycle T produces we_o=1 with that waddr/wdata in cycle T+1.
  - Otherwise we_o=0 in T+1; waddr_o/wdata_o hold their last values.
  - Transfers with waddr==0 are accepted (ready behaves normally), but we_o stays 0 in T+1.
  - Output stage records source (ALU/LSU).
- Scoreboard (REG_COUNT-bit pending vector, bit 0 constant 0):
  - Set: issue_load_i=1 and issue_rd_i!=0 sets pending[issue_rd_i] at the edge.
  - Clear: pending[waddr_o] is cleared at the end of a cycle where we_o=1 and the source is LSU. The register file is updated at that same edge, so a read in the next cycle sees the new data.
  - Set and clear of the same register in the same cycle: set wins (a new load is outstanding).
  - hazard_o = (pending[query_a_i] & query_a_i!=0) | (pending[query_b_i] & query_b_i!=0); combinational from the registered pending vector.
  - An ALU write to a pending register does not clear it (WAW ordering is the issue logic's responsibility).

Decomposition:
- Shared core package holds:
  - REG_COUNT, ADDR_WIDTH, DATA_WIDTH constants
  - wb_src_e enum {WB_SRC_ALU, WB_SRC_LSU}
  - wb_req_t struct {waddr, wdata}
- One natural sub-module: regfile_scoreboard (pending vector, set/clear, dual query → hazard_o). Arbitration and the output stage stay in the top module.

Test Plan:
- Reset then idle: rst_n low mid-cycle → we_o=0 immediately, hazard_o=0 for all queries, both ready=0 during reset, ready=1 after release.
- Single ALU write: alu_valid=1, waddr=5, wdata=0xDEADBEEF → alu_ready=1 same cycle; next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; following cycle we_o=0.
- Contention and starvation: both valid continuously (alu waddr=3, lsu waddr=7):
  - LSU granted 4 consecutive cycles.
  - 5th cycle ALU granted, lsu_ready=0.
  - LSU then resumes.
- x0 write: lsu_valid=1, waddr=0, wdata=0x1234 → lsu_ready=1, we_o stays 0 the next cycle.
- Scoreboard lifecycle: issue_load rd=9; query_a=9 → hazard_o=1 next cycle. LSU writeback rd=9 accepted in T → hazard_o still 1 in T+1 (we_o=1), hazard_o=0 in T+2.
- Set/clear collision: pending[9] set, LSU commit for rd=9 in the same cycle as issue_load rd=9 → pending[9] remains 1, hazard_o=1 for query 9.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Imported by the interface, the scoreboard and the arbiter top.
package regfile_wb_arbiter_pkg;

  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  // x0 is hardwired to zero, so writes to it and loads into it are ignored.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two requester handshakes, load-issue/decode
// query signals and the register-file write port.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
();

  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [ADDR_WIDTH-1:0] alu_waddr_i;
  logic [DATA_WIDTH-1:0] alu_wdata_i;

  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;

  logic                  issue_load_i;
  logic [ADDR_WIDTH-1:0] issue_rd_i;
  logic [ADDR_WIDTH-1:0] query_a_i;
  logic [ADDR_WIDTH-1:0] query_b_i;
  logic                  hazard_o;

  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  we_o;

  // The core side (requesters, issue, decode, register file) drives the inputs.
  modport master (
    output alu_valid_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output issue_load_i, issue_rd_i, query_a_i, query_b_i,
    input  alu_ready_o, lsu_ready_o, hazard_o,
    input  waddr_o, wdata_o, we_o
  );

  modport slave (
    input  alu_valid_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  issue_load_i, issue_rd_i, query_a_i, query_b_i,
    output alu_ready_o, lsu_ready_o, hazard_o,
    output waddr_o, wdata_o, we_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set on load issue,
// cleared on load writeback commit, queried by decode for RAW hazards.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] query_a,
  input  logic [ADDR_WIDTH-1:0] query_b,
  output logic                  hazard
);

  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;

  // Clear is applied first so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (set_en && !is_zero_reg(set_addr)) begin
      pending_d[set_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: the pending vector is a handful of flops, not a RAM, so it is reset
  // explicitly; a stale bit after reset would stall decode forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign hazard = (pending_q[query_a] && !is_zero_reg(query_a)) ||
                  (pending_q[query_b] && !is_zero_reg(query_b));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the LSU
// load-return path, with a registered write stage and a pending-load scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             starve;
  logic             alu_ready;
  logic             lsu_ready;
  logic             alu_xfer;
  logic             lsu_xfer;

  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t sel_req;
  wb_req_t out_q;
  wb_src_e src_q;
  logic    we_q;

  assign alu_req = '{waddr: bus.alu_waddr_i, wdata: bus.alu_wdata_i};
  assign lsu_req = '{waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i};

  // LSU has fixed priority unless the ALU has been denied MAX_WAIT cycles in a row.
  // Readies are gated by rst_n so nothing is accepted while the stage is held in reset.
  assign starve    = (wait_cnt_q == MAX_CNT);
  assign lsu_ready = rst_n && !starve;
  assign alu_ready = rst_n && (starve || !bus.lsu_valid_i);

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;

  assign alu_xfer = bus.alu_valid_i && alu_ready;
  assign lsu_xfer = bus.lsu_valid_i && lsu_ready;

  // The two grants are mutually exclusive, so the LSU check order is arbitrary.
  assign sel_req = lsu_xfer ? lsu_req : alu_req;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.alu_valid_i || alu_xfer) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: every flop here is assigned with <= so all state updates from the same
  // edge see pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output stage: writes to x0 are accepted upstream but never raise we_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      src_q <= WB_SRC_ALU;
      we_q  <= 1'b0;
    end else begin
      we_q <= (alu_xfer || lsu_xfer) && !is_zero_reg(sel_req.waddr);
      if (alu_xfer || lsu_xfer) begin
        out_q <= sel_req;
        src_q <= lsu_xfer ? WB_SRC_LSU : WB_SRC_ALU;
      end
    end
  end

  assign bus.we_o    = we_q;
  assign bus.waddr_o = out_q.waddr;
  assign bus.wdata_o = out_q.wdata;

  // A load's pending bit drops at the same edge the register file takes its data.
  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.issue_load_i),
    .set_addr (bus.issue_rd_i),
    .clr_en   (we_q && (src_q == WB_SRC_LSU)),
    .clr_addr (out_q.waddr),
    .query_a  (bus.query_a_i),
    .query_b  (bus.query_b_i),
    .hazard   (bus.hazard_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU write, contention/starvation,
// x0 writes, scoreboard set/clear and mid-cycle reset.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i  = 1'b0;
    bus.alu_waddr_i  = '0;
    bus.alu_wdata_i  = '0;
    bus.lsu_valid_i  = 1'b0;
    bus.lsu_waddr_i  = '0;
    bus.lsu_wdata_i  = '0;
    bus.issue_load_i = 1'b0;
    bus.issue_rd_i   = '0;
  endtask

  // Advance one full cycle: the rising edge, then stop at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.query_a_i = 5'd9;
    bus.query_b_i = 5'd0;

    // Reset state: outputs cleared, readies forced low even though LSU is idle.
    repeat (2) @(negedge clk);
    check("rst_we", 32'(bus.we_o), 32'd0);
    check("rst_waddr", 32'(bus.waddr_o), 32'd0);
    check("rst_wdata", bus.wdata_o, 32'd0);
    check("rst_hazard", 32'(bus.hazard_o), 32'd0);
    check("rst_alu_ready", 32'(bus.alu_ready_o), 32'd0);
    check("rst_lsu_ready", 32'(bus.lsu_ready_o), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
    check("post_rst_lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
    step();

    // Single ALU write.
    bus.alu_valid_i = 1'b1;
    bus.alu_waddr_i = 5'd5;
    bus.alu_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("alu_ready", 32'(bus.alu_ready_o), 32'd1);
    step();
    idle_inputs();
    check("alu_we", 32'(bus.we_o), 32'd1);
    check("alu_waddr", 32'(bus.waddr_o), 32'd5);
    check("alu_wdata", bus.wdata_o, 32'hDEAD_BEEF);
    step();
    check("alu_we_drop", 32'(bus.we_o), 32'd0);
    check("alu_waddr_hold", 32'(bus.waddr_o), 32'd5);

    // Contention: LSU wins four cycles, ALU gets the fifth, LSU resumes.
    bus.alu_valid_i = 1'b1;
    bus.alu_waddr_i = 5'd3;
    bus.alu_wdata_i = 32'h0000_0A1A;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = 5'd7;
    bus.lsu_wdata_i = 32'h0000_0F5F;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont_lsu_ready[%0d]", i), 32'(bus.lsu_ready_o), (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("cont_alu_ready[%0d]", i), 32'(bus.alu_ready_o), (i == 4) ? 32'd1 : 32'd0);
      step();
      check($sformatf("cont_we[%0d]", i), 32'(bus.we_o), 32'd1);
      check($sformatf("cont_waddr[%0d]", i), 32'(bus.waddr_o), (i == 4) ? 32'd3 : 32'd7);
      check($sformatf("cont_wdata[%0d]", i), bus.wdata_o, (i == 4) ? 32'h0A1A : 32'h0F5F);
    end
    idle_inputs();
    step();

    // x0 write: accepted but never committed.
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = 5'd0;
    bus.lsu_wdata_i = 32'h0000_1234;
    #1;
    check("x0_lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
    step();
    idle_inputs();
    check("x0_we", 32'(bus.we_o), 32'd0);

    // Scoreboard lifecycle on x9.
    bus.issue_load_i = 1'b1;
    bus.issue_rd_i   = 5'd9;
    #1;
    check("sb_pre_set_hazard", 32'(bus.hazard_o), 32'd0);
    step();
    idle_inputs();
    check("sb_set_hazard_a", 32'(bus.hazard_o), 32'd1);
    bus.query_a_i = 5'd0;
    bus.query_b_i = 5'd9;
    #1;
    check("sb_set_hazard_b", 32'(bus.hazard_o), 32'd1);
    bus.query_a_i = 5'd9;
    bus.query_b_i = 5'd0;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = 5'd9;
    bus.lsu_wdata_i = 32'hCAFE_0009;
    step();
    idle_inputs();
    check("sb_commit_we", 32'(bus.we_o), 32'd1);
    check("sb_commit_waddr", 32'(bus.waddr_o), 32'd9);
    check("sb_commit_hazard", 32'(bus.hazard_o), 32'd1);
    step();
    check("sb_cleared_hazard", 32'(bus.hazard_o), 32'd0);

    // ALU write to a pending register must not clear it.
    bus.issue_load_i = 1'b1;
    bus.issue_rd_i   = 5'd12;
    step();
    idle_inputs();
    bus.alu_valid_i = 1'b1;
    bus.alu_waddr_i = 5'd12;
    bus.alu_wdata_i = 32'h0000_00AA;
    step();
    idle_inputs();
    check("waw_alu_we", 32'(bus.we_o), 32'd1);
    step();
    bus.query_a_i = 5'd12;
    #1;
    check("waw_still_pending", 32'(bus.hazard_o), 32'd1);
    bus.query_a_i = 5'd9;

    // Set/clear collision on x9: the new issue wins over the commit.
    bus.issue_load_i = 1'b1;
    bus.issue_rd_i   = 5'd9;
    step();
    idle_inputs();
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = 5'd9;
    bus.lsu_wdata_i = 32'h0000_0099;
    step();
    idle_inputs();
    bus.issue_load_i = 1'b1;
    bus.issue_rd_i   = 5'd9;
    check("coll_we", 32'(bus.we_o), 32'd1);
    step();
    idle_inputs();
    check("coll_hazard", 32'(bus.hazard_o), 32'd1);

    // Reset while a write sits in the output stage: it is dropped immediately.
    bus.alu_valid_i = 1'b1;
    bus.alu_waddr_i = 5'd20;
    bus.alu_wdata_i = 32'h5555_AAAA;
    @(posedge clk);
    #2;
    idle_inputs();
    check("mid_pre_we", 32'(bus.we_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.we_o), 32'd0);
    check("mid_rst_waddr", 32'(bus.waddr_o), 32'd0);
    check("mid_rst_hazard", 32'(bus.hazard_o), 32'd0);
    check("mid_rst_alu_ready", 32'(bus.alu_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_mid_we", 32'(bus.we_o), 32'd0);
    check("post_mid_wdata", bus.wdata_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
